// File: rtl/sap1_display_pkg.sv
// Shared types and segment constants for the SAP-1 output display scanner.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package sap1_display_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConvert = 2'd1,
    StCommit  = 2'd2
  } conv_state_e;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-decimal codes show blank.
module seven_seg_decoder
  import sap1_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segments_n
);

  always_comb begin
    segments_n = SEG_BLANK;
    unique case (bcd)
      4'd0:    segments_n = SEG_0;
      4'd1:    segments_n = SEG_1;
      4'd2:    segments_n = SEG_2;
      4'd3:    segments_n = SEG_3;
      4'd4:    segments_n = SEG_4;
      4'd5:    segments_n = SEG_5;
      4'd6:    segments_n = SEG_6;
      4'd7:    segments_n = SEG_7;
      4'd8:    segments_n = SEG_8;
      4'd9:    segments_n = SEG_9;
      default: segments_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/output_display_scanner.sv
// SAP-1 output display: sequential double-dabble binary-to-BCD plus 3-digit scan.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros on the hundreds and tens digits.
module output_display_scanner
  import sap1_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        Clock,
  input  logic        reset_n,
  input  logic [7:0]  value_in,
  output logic        busy,
  output logic [11:0] bcd_out,
  output logic [2:0]  anode_n,
  output logic [6:0]  segments_n
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LzBlank = 1'b1;
`else
  localparam logic LzBlank = 1'b0;
`endif

  localparam logic [15:0] PrescMax = 16'(SCAN_DIV - 1);

  conv_state_e state_q, state_d;
  logic [7:0]  last_value_q, last_value_d;
  logic [19:0] shift_q, shift_d;
  logic [19:0] shift_adj;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] bcd_q, bcd_d;

  logic [15:0] presc_q, presc_d;
  digit_idx_t  digit_sel_q, digit_sel_d;
  logic [2:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic [6:0]  dec_seg;
  logic        wrap;

  // Converter
  assign shift_adj = {add3_if_ge5(shift_q[19:16]), add3_if_ge5(shift_q[15:12]),
                      add3_if_ge5(shift_q[11:8]), shift_q[7:0]};

  always_comb begin
    state_d      = state_q;
    last_value_d = last_value_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    bcd_d        = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (value_in != last_value_q) begin
          shift_d      = {12'h000, value_in};
          last_value_d = value_in;
          bit_cnt_d    = 3'd0;
          state_d      = StConvert;
        end
      end
      StConvert: begin
        shift_d   = {shift_adj[18:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = StCommit;
      end
      StCommit: begin
        bcd_d   = shift_q[19:8];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_value_q <= 8'h00;
      shift_q      <= 20'h00000;
      bit_cnt_q    <= 3'd0;
      bcd_q        <= 12'h000;
    end else begin
      state_q      <= state_d;
      last_value_q <= last_value_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      bcd_q        <= bcd_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign bcd_out = bcd_q;

  // Scanner: outputs are registered from the next digit index so anode and
  // segments switch together on the wrap edge.
  assign wrap = (presc_q == PrescMax);

  always_comb begin
    presc_d     = wrap ? 16'd0 : presc_q + 16'd1;
    digit_sel_d = digit_sel_q;
    if (wrap) digit_sel_d = (digit_sel_q == 2'd2) ? 2'd0 : digit_sel_q + 2'd1;
  end

  always_comb begin
    cur_digit = bcd_q[3:0];
    cur_blank = 1'b0;
    anode_d   = 3'b110;
    unique case (digit_sel_d)
      2'd1: begin
        cur_digit = bcd_q[7:4];
        cur_blank = LzBlank && (bcd_q[11:4] == 8'h00);
        anode_d   = 3'b101;
      end
      2'd2: begin
        cur_digit = bcd_q[11:8];
        cur_blank = LzBlank && (bcd_q[11:8] == 4'h0);
        anode_d   = 3'b011;
      end
      default: begin
        cur_digit = bcd_q[3:0];
        cur_blank = 1'b0;
        anode_d   = 3'b110;
      end
    endcase
    seg_d = cur_blank ? SEG_BLANK : dec_seg;
  end

  seven_seg_decoder u_dec (
    .bcd        (cur_digit),
    .segments_n (dec_seg)
  );

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= 16'd0;
      digit_sel_q <= 2'd0;
      anode_q     <= 3'b110;
      seg_q       <= SEG_0;
    end else begin
      presc_q     <= presc_d;
      digit_sel_q <= digit_sel_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
    end
  end

  assign anode_n    = anode_q;
  assign segments_n = seg_q;

endmodule

// File: tb/tb_output_display_scanner.sv
// Directed self-checking bench for output_display_scanner (short scan period).
module tb_output_display_scanner;
  import sap1_display_pkg::*;

  localparam int unsigned ScanDiv = 4;

  logic        Clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  value_in = 8'd0;
  logic        busy;
  logic [11:0] bcd_out;
  logic [2:0]  anode_n;
  logic [6:0]  segments_n;

  int n_checks = 0;
  int n_errors = 0;

  output_display_scanner #(.SCAN_DIV(ScanDiv)) dut (
    .Clock      (Clock),
    .reset_n    (reset_n),
    .value_in   (value_in),
    .busy       (busy),
    .bcd_out    (bcd_out),
    .anode_n    (anode_n),
    .segments_n (segments_n)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Counts negedges with busy high until busy drops; bounded.
  task automatic run_conv(output int cnt, output logic first_busy);
    cnt = 0;
    first_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (i == 0) first_busy = busy;
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  task automatic convert(input string tag, input logic [7:0] val, input logic [11:0] exp_bcd);
    int   cnt;
    logic fb;
    value_in = val;
    run_conv(cnt, fb);
    check_eq({tag, "_busy_rise"}, fb, 1);
    check_eq({tag, "_busy_len"}, cnt, 9);
    check_eq({tag, "_bcd"}, bcd_out, exp_bcd);
  endtask

  task automatic scan_check(input string tag, input logic [6:0] s_ones,
                            input logic [6:0] s_tens, input logic [6:0] s_hund);
    logic [2:0] exp_an [3];
    logic [6:0] exp_sg [3];
    logic [2:0] prev;
    logic       found;
    int         hold;
    exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011;
    exp_sg[0] = s_ones; exp_sg[1] = s_tens; exp_sg[2] = s_hund;
    found = 1'b0;
    prev = anode_n;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (anode_n == 3'b110 && prev != 3'b110) begin
        found = 1'b1;
        break;
      end
      prev = anode_n;
    end
    check_eq({tag, "_sync"}, found, 1);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_anode%0d", tag, k), anode_n, exp_an[k]);
      check_eq($sformatf("%s_seg%0d", tag, k), segments_n, exp_sg[k]);
      hold = 1;
      for (int j = 0; j < 20; j++) begin
        @(negedge Clock);
        if (anode_n == exp_an[k]) hold++;
        else break;
      end
      check_eq($sformatf("%s_hold%0d", tag, k), hold, ScanDiv);
    end
    check_eq({tag, "_anode_wrap"}, anode_n, 3'b110);
  endtask

  initial begin
    int   cnt;
    logic fb;

    #2 reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    check_eq("rst_bcd", bcd_out, 12'h000);
    check_eq("rst_anode", anode_n, 3'b110);
    check_eq("rst_seg", segments_n, SEG_0);
    check_eq("rst_busy", busy, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      check_eq($sformatf("idle_busy%0d", i), busy, 0);
    end

    convert("v255", 8'd255, 12'h255);
    scan_check("scan255", SEG_5, SEG_5, SEG_2);
    convert("v128", 8'd128, 12'h128);
    convert("v9", 8'd9, 12'h009);

    // Change input mid-conversion: first result stays 100, 200 follows.
    value_in = 8'd100;
    repeat (3) @(negedge Clock);
    value_in = 8'd200;
    run_conv(cnt, fb);
    check_eq("mid_busy_rest", cnt, 6);
    check_eq("mid_bcd100", bcd_out, 12'h100);
    run_conv(cnt, fb);
    check_eq("mid_busy_rise", fb, 1);
    check_eq("mid_busy_len", cnt, 9);
    check_eq("mid_bcd200", bcd_out, 12'h200);

    // Reset in the middle of converting 77.
    value_in = 8'd77;
    repeat (4) @(negedge Clock);
    check_eq("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_bcd", bcd_out, 12'h000);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_anode", anode_n, 3'b110);
    check_eq("midrst_seg", segments_n, SEG_0);
    @(negedge Clock);
    reset_n = 1'b1;
    run_conv(cnt, fb);
    check_eq("re77_busy_rise", fb, 1);
    check_eq("re77_busy_len", cnt, 9);
    check_eq("re77_bcd", bcd_out, 12'h077);

    value_in = 8'd7;
    run_conv(cnt, fb);
    check_eq("v7_bcd", bcd_out, 12'h007);
`ifdef LEADING_ZERO_BLANK_EN
    scan_check("scan007", SEG_7, SEG_BLANK, SEG_BLANK);
`else
    scan_check("scan007", SEG_7, SEG_0, SEG_0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/output_display_scanner.md
Name: output_display_scanner

Overview:
Drives a 3-digit multiplexed common-anode 7-segment display from the 8-bit output register value of the SAP-1.
- Converts the unsigned value to BCD with a sequential double-dabble engine, one shift per clock.
- Time-multiplexes the three digits with a prescaled scan counter.
- Sits between the output register's display bus and the board's segment and anode pins.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays lit; legal range 2..65535.

Ports:
Clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
value_in  input  8  unsigned value from the output register's display bus
busy  output  1  high while a conversion is in progress (CONVERT or COMMIT)
bcd_out  output  12  committed BCD digits {hundreds, tens, ones}
anode_n  output  3  active-low digit enables; bit0 = ones, bit2 = hundreds
segments_n  output  7  active-low segments {g,f,e,d,c,b,a}

Behaviour:
- Clocking and reset:
  - One clock, Clock. Reset is asynchronous and active-low on reset_n.
  - While reset_n is low, all state is forced immediately.
  - Reset values: state = IDLE, last_value = 0, bcd_out = 12'h000, busy = 0, prescaler = 0, digit_sel = 0, anode_n = 3'b110, segments_n = 7'b1000000 (digit '0').
- Converter FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - Each edge compares value_in with last_value.
  - If they differ: load shift register {12'h000, value_in}, set last_value <= value_in, clear bit counter, go to CONVERT.
  - If they are equal: stay in IDLE.
- CONVERT, each edge:
  - Add 3 to every BCD nibble that is >= 5.
  - Then shift the whole 20-bit register left by 1.
  - After the 8th shift (bit counter == 7), go to COMMIT.
- COMMIT: bcd_out <= upper 12 bits of the shift register, then go to IDLE.
- Latency: value sampled at edge E0; shifts on E1..E8; bcd_out updates at E9; segments_n reflects the new value at E10.
- value_in changes during CONVERT or COMMIT are ignored. The new value is detected at the first IDLE edge after COMMIT. Only the value present at that edge is converted; intermediate values are lost.
- A conversion never starts if value_in equals last_value. After reset, a value of 0 causes no conversion.
- busy = 1 in CONVERT and COMMIT, and 0 in IDLE.
- Scan logic:
  - The prescaler counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap edge, digit_sel advances 0 -> 1 -> 2 -> 0.
  - anode_n and segments_n are registered every edge from the next-state digit_sel and the current bcd_out. A new digit and its segments therefore appear together on the wrap edge.
  - anode_n is always exactly one-hot-low. All 3 anodes are never enabled at once, even in reset.
- Segment encoding for BCD digits 0-9 is the standard one. Codes 10-15 cannot occur and map to blank (7'h7F).
- Reset mid-conversion: the partial result is discarded, bcd_out returns to 000, and the FSM returns to IDLE.

Optional Feature:
LEADING_ZERO_BLANK_EN
- When defined:
  - The hundreds digit shows blank (7'h7F) if it is 0.
  - The tens digit shows blank if the hundreds and tens digits are both 0.
  - The ones digit is never blanked; value 0 shows "  0".
  - The anode is still driven, so scan timing is unchanged.
- When not defined, leading zeros are displayed ("007").
- bcd_out is unaffected in both cases.

Decomposition:
- Package sap1_display_pkg holds:
  - The converter state enum (IDLE, CONVERT, COMMIT).
  - A 2-bit digit-index typedef.
  - Active-low segment constants SEG_0..SEG_9 and SEG_BLANK.
- One sub-module: seven_seg_decoder, a purely combinational 4-bit BCD to 7-bit active-low segment decoder.

Test Plan:
- Reset: hold reset_n low -> bcd_out = 000, anode_n = 110, segments_n = 1000000, busy = 0. Keep value_in = 0 after release -> busy stays 0 for 20 cycles.
- value_in = 255 -> busy rises the cycle after E0 and stays high 9 cycles; bcd_out = 12'h255 at E9. Repeat for value_in = 128 -> 12'h128, and value_in = 9 -> 12'h009.
- SCAN_DIV = 4, bcd_out = 255 -> anode_n steps 110 -> 101 -> 011 -> 110, each held exactly 4 cycles; segments_n = SEG_5, SEG_5, SEG_2 in step with those anodes.
- value_in 100 -> 200 at E3 of a conversion -> bcd_out = 100 first, then a second conversion starting at the first IDLE edge ends with bcd_out = 200.
- reset_n pulsed low at E4 of the conversion of 77 -> bcd_out = 000 and FSM in IDLE immediately. After release, 77 is reconverted and bcd_out = 077.
- With LEADING_ZERO_BLANK_EN, value_in = 7 -> hundreds and tens slots show 7'h7F and ones shows SEG_7. Without the macro -> SEG_0, SEG_0, SEG_7.
